// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller.
//   mdu_state_e : controller states (Idle, Mul, Div, Done)
//   Mdu*        : op_i encodings for MULT / MULTU / DIV / DIVU
//   is_div_op, is_signed_op : op decode helpers
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StDiv  = 2'b10,
        StDone = 2'b11
    } mdu_state_e;

    localparam logic [1:0] MduMult  = 2'b00;
    localparam logic [1:0] MduMultu = 2'b01;
    localparam logic [1:0] MduDiv   = 2'b10;
    localparam logic [1:0] MduDivu  = 2'b11;

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == MduDiv) || (op == MduDivu);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == MduMult) || (op == MduDiv);
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
//   rem, quot  : partial remainder and the dividend bits still being shifted out (quotient
//                bits are shifted in at the bottom)
//   divisor    : unsigned divisor magnitude
//   rem_next, quot_next : values after shifting one bit and conditionally subtracting
module muldiv_div_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quot,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quot_next
);

    // One extra bit: the shifted remainder can reach 2*divisor-1, which overflows DATA_W
    // when the divisor has its top bit set.
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;
    logic            fits;

    always_comb begin
        shifted   = {rem, quot[DATA_W-1]};
        diff      = shifted - {1'b0, divisor};
        fits      = ~diff[DATA_W];
        rem_next  = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quot_next = {quot[DATA_W-2:0], fits};
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage.
// Accepts MULT/MULTU/DIV/DIVU while idle, runs a 2-cycle multiply or a 32-step restoring
// divide, stalls the pipeline meanwhile and issues a single HI/LO write with the result.
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   start_i       mult/div instruction present in EX (held while stalled)
//   op_i          operation select (MduMult/MduMultu/MduDiv/MduDivu)
//   src_a_i       multiplicand / dividend
//   src_b_i       multiplier / divisor
//   flush_i       abort any operation, suppress the HI/LO write
//   stall_o       pipeline stall request
//   busy_o        controller not idle
//   done_o        one-cycle result-valid pulse
//   hilo_we_o     HI/LO write enable (same as done_o)
//   hi_o, lo_o    product high/low or remainder/quotient
//   div_zero_o    only with MULDIV_DIV0_FLAG_EN: pulses with done_o for a divide by zero
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              hilo_we_o,
`ifdef MULDIV_DIV0_FLAG_EN
    output logic              div_zero_o,
`endif
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    mdu_state_e state_q, state_d;
    logic [1:0]        op_q, op_d;
    // a_q doubles as the running quotient during a divide; b_q holds |divisor|.
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_quot_q, neg_quot_d;
    logic              neg_rem_q, neg_rem_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
`ifdef MULDIV_DIV0_FLAG_EN
    logic              div0_q, div0_d;
`endif

    logic [2*DATA_W-1:0] a_ext, b_ext, product;
    logic [DATA_W-1:0]   step_rem, step_quot;
    logic [DATA_W-1:0]   src_a_mag, src_b_mag;
    logic                op_signed;

    muldiv_div_step #(
        .DATA_W(DATA_W)
    ) u_div_step (
        .rem      (rem_q),
        .quot     (a_q),
        .divisor  (b_q),
        .rem_next (step_rem),
        .quot_next(step_quot)
    );

    // Sign-extend for MULT so the low 2*DATA_W bits of the product are the signed result.
    always_comb begin
        a_ext   = {{DATA_W{is_signed_op(op_q) & a_q[DATA_W-1]}}, a_q};
        b_ext   = {{DATA_W{is_signed_op(op_q) & b_q[DATA_W-1]}}, b_q};
        product = a_ext * b_ext;
    end

    always_comb begin
        op_signed = is_signed_op(op_i);
        src_a_mag = (op_signed && src_a_i[DATA_W-1]) ? -src_a_i : src_a_i;
        src_b_mag = (op_signed && src_b_i[DATA_W-1]) ? -src_b_i : src_b_i;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
`ifdef MULDIV_DIV0_FLAG_EN
        div0_d     = div0_q;
`endif

        if (flush_i) begin
            // Flush wins everywhere, including over a start in Idle and the final divide step.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        op_d = op_i;
`ifdef MULDIV_DIV0_FLAG_EN
                        div0_d = 1'b0;
`endif
                        if (!is_div_op(op_i)) begin
                            a_d     = src_a_i;
                            b_d     = src_b_i;
                            state_d = StMul;
                        end else if (src_b_i == '0) begin
                            hi_d    = src_a_i;
                            lo_d    = '1;
                            state_d = StDone;
`ifdef MULDIV_DIV0_FLAG_EN
                            div0_d  = 1'b1;
`endif
                        end else begin
                            a_d        = src_a_mag;
                            b_d        = src_b_mag;
                            rem_d      = '0;
                            cnt_d      = '0;
                            neg_quot_d = op_signed & (src_a_i[DATA_W-1] ^ src_b_i[DATA_W-1]);
                            neg_rem_d  = op_signed & src_a_i[DATA_W-1];
                            state_d    = StDiv;
                        end
                    end
                end
                StMul: begin
                    hi_d    = product[2*DATA_W-1:DATA_W];
                    lo_d    = product[DATA_W-1:0];
                    state_d = StDone;
                end
                StDiv: begin
                    rem_d = step_rem;
                    a_d   = step_quot;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        lo_d    = neg_quot_q ? -step_quot : step_quot;
                        hi_d    = neg_rem_q ? -step_rem : step_rem;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    // The same instruction is still in EX this cycle, so start_i is ignored.
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    always_comb begin
        stall_o   = ~rst & (((state_q == StIdle) & start_i & ~flush_i) |
                            (state_q == StMul) | (state_q == StDiv));
        busy_o    = (state_q != StIdle);
        done_o    = ~rst & ~flush_i & (state_q == StDone);
        hilo_we_o = done_o;
        hi_o      = hi_q;
        lo_o      = lo_q;
    end

`ifdef MULDIV_DIV0_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            div0_q <= 1'b0;
        end else begin
            div0_q <= div0_d;
        end
    end

    assign div_zero_o = done_o & div0_q;
`else
    // Without the flag, a divide by zero is visible only through the HI/LO result.
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stall;
    logic        busy;
    logic        done;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MULDIV_DIV0_FLAG_EN
    logic        div_zero;
`endif

    muldiv_ctrl #(
        .DATA_W(32),
        .CNT_W (6)
    ) dut (
`ifdef MULDIV_DIV0_FLAG_EN
        .div_zero_o(div_zero),
`endif
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .op_i     (op),
        .src_a_i  (src_a),
        .src_b_i  (src_b),
        .flush_i  (flush),
        .stall_o  (stall),
        .busy_o   (busy),
        .done_o   (done),
        .hilo_we_o(hilo_we),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference results straight from the arithmetic definition of each instruction.
    function automatic void model_res(input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] rhi,
                                      output logic [31:0] rlo, output int lat,
                                      output bit dz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        dz = 1'b0;
        if (o == 2'b00 || o == 2'b01) begin
            if (o == 2'b00) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
            end else begin
                p = {32'h0, a} * {32'h0, b};
            end
            rhi = p[63:32];
            rlo = p[31:0];
            lat = 2;
        end else if (b == 32'h0) begin
            rhi = a;
            rlo = 32'hFFFF_FFFF;
            lat = 1;
            dz  = 1'b1;
        end else begin
            if (o == 2'b10) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'h0, a});
                sb = longint'({32'h0, b});
            end
            q   = sa / sb;
            r   = sa % sb;
            rlo = q[31:0];
            rhi = r[31:0];
            lat = 33;
        end
    endfunction

    // Cycle-level model: an operation is either idle, counting down to its done cycle, or in it.
    bit          chk_en   = 1'b0;
    bit          m_active = 1'b0;
    int          m_left   = 0;
    int          m_lat;
    bit          m_dz     = 1'b0;
    logic [31:0] m_hold_hi = '0;
    logic [31:0] m_hold_lo = '0;
    logic [31:0] m_res_hi, m_res_lo;
    logic        e_stall, e_done, e_busy;

    always @(negedge clk) begin
        if (chk_en) begin
            e_busy = m_active;
            if (rst) begin
                e_stall = 1'b0;
                e_done  = 1'b0;
            end else if (m_active && m_left == 0) begin
                e_stall = 1'b0;
                e_done  = !flush;
            end else if (m_active) begin
                e_stall = 1'b1;
                e_done  = 1'b0;
            end else begin
                e_stall = start && !flush;
                e_done  = 1'b0;
            end
            chk("stall_o", 32'(stall), 32'(e_stall));
            chk("busy_o", 32'(busy), 32'(e_busy));
            chk("done_o", 32'(done), 32'(e_done));
            chk("hilo_we_o", 32'(hilo_we), 32'(e_done));
            chk("hi_o", hi, m_hold_hi);
            chk("lo_o", lo, m_hold_lo);
`ifdef MULDIV_DIV0_FLAG_EN
            chk("div_zero_o", 32'(div_zero), 32'(e_done & m_dz));
`endif
            if (rst) begin
                m_active  = 1'b0;
                m_hold_hi = '0;
                m_hold_lo = '0;
            end else if (flush) begin
                m_active = 1'b0;
            end else if (m_active && m_left == 0) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_left--;
                if (m_left == 0) begin
                    m_hold_hi = m_res_hi;
                    m_hold_lo = m_res_lo;
                end
            end else if (start) begin
                model_res(op, src_a, src_b, m_res_hi, m_res_lo, m_lat, m_dz);
                m_active = 1'b1;
                m_left   = m_lat - 1;
                if (m_left == 0) begin
                    m_hold_hi = m_res_hi;
                    m_hold_lo = m_res_lo;
                end
            end
        end
    end

    // Issue one operation, hold start through the done cycle, check hand-computed results.
    task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int exp_lat);
        logic [31:0] mh, ml;
        int          mlat;
        bit          mdz;
        int          t0;
        bit          got;
        model_res(o, a, b, mh, ml, mlat, mdz);
        chk({name, "_model_hi"}, mh, exp_hi);
        chk({name, "_model_lo"}, ml, exp_lo);
        chk({name, "_model_lat"}, 32'(mlat), 32'(exp_lat));
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        t0    = cyc;
        got   = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                chk({name, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
                chk({name, "_hi"}, hi, exp_hi);
                chk({name, "_lo"}, lo, exp_lo);
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done_o, expected one within 60 cycles", name);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    int done_seen;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);

        do_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2);
        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2);
        do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        do_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        do_op("divu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
        do_op("div_m3_0", 2'b10, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1);
        do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        do_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        do_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 33);

        // Flush in the middle of a divide: back to idle, no write ever appears.
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b10;
        src_a = 32'd1000;
        src_b = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_next", 32'(busy), 32'h0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("flush_no_done", 32'(done_seen), 32'h0);

        // Reset in the middle of a divide, then a fresh multiply.
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b10;
        src_a = 32'd77;
        src_b = 32'd5;
        repeat (5) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_stall", 32'(stall), 32'h0);
        chk("rst_mid_done", 32'(done), 32'h0);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        do_op("mult_3x4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 2);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
